// File: rtl/sad_min_search.sv
// Reduces per-row partial SADs to block SADs and tracks the minimum-SAD
// candidate over a search window of NUM_BATCHES accepted beats.
module sad_min_search #(
  parameter int PIXELS_IN_BATCH = 16,
  parameter int EDGE_LEN        = 8,
  parameter int PSAD_BIT_WIDTH  = 11,
  parameter int SAD_BIT_WIDTH   = 14,
  parameter int NUM_BATCHES     = 64,
  localparam int IDX_WIDTH      = $clog2(NUM_BATCHES * PIXELS_IN_BATCH)
) (
  input  logic                                                clk_i,
  input  logic                                                rst_n_i,
  input  logic                                                start_i,
  input  logic                                                valid_i,
  input  logic [PSAD_BIT_WIDTH*EDGE_LEN*PIXELS_IN_BATCH-1:0]  psad_addend_batch,
  output logic                                                busy_o,
  output logic                                                done_o,
  output logic [SAD_BIT_WIDTH-1:0]                            best_sad_o,
  output logic [IDX_WIDTH-1:0]                                best_idx_o
);

  localparam int BATCH_W = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
  localparam int LIDX_W  = (PIXELS_IN_BATCH > 1) ? $clog2(PIXELS_IN_BATCH) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

  state_e                   state_q, state_d;
  logic [BATCH_W-1:0]       batch_q, batch_d;
  logic                     drain_q, drain_d;
  logic                     accept, last_beat, load_best;
  logic [BATCH_W-1:0]       beat_batch;

  logic                                          s1_vld_q, s1_vld_d;
  logic [BATCH_W-1:0]                            s1_batch_q, s1_batch_d;
  logic [PIXELS_IN_BATCH-1:0][SAD_BIT_WIDTH-1:0] s1_sad_q, s1_sad_d;

  logic                     s2_vld_q, s2_vld_d;
  logic [BATCH_W-1:0]       s2_batch_q, s2_batch_d;
  logic [SAD_BIT_WIDTH-1:0] s2_sad_q, s2_sad_d;
  logic [LIDX_W-1:0]        s2_lidx_q, s2_lidx_d;

  logic [SAD_BIT_WIDTH-1:0] run_sad_q, run_sad_d;
  logic [IDX_WIDTH-1:0]     run_idx_q, run_idx_d;
  logic [IDX_WIDTH-1:0]     s2_gidx;
  logic [SAD_BIT_WIDTH-1:0] best_sad_q, best_sad_d;
  logic [IDX_WIDTH-1:0]     best_idx_q, best_idx_d;

  always_comb begin
    state_d    = state_q;
    batch_d    = batch_q;
    drain_d    = drain_q;
    accept     = valid_i && (start_i || state_q == ACCUM);
    beat_batch = start_i ? '0 : batch_q;
    last_beat  = accept && (beat_batch == BATCH_W'(NUM_BATCHES - 1));
    load_best  = (state_q == DRAIN) && drain_q && !start_i;

    unique case (state_q)
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase

    // start_i overrides everything, including an in-flight window
    if (start_i) begin
      state_d = ACCUM;
      batch_d = '0;
      drain_d = 1'b0;
    end
    if (accept) batch_d = beat_batch + 1'b1;
    if (last_beat) begin
      state_d = DRAIN;
      batch_d = '0;
      drain_d = 1'b0;
    end
  end

  always_comb begin
    s1_vld_d   = accept;
    s1_batch_d = accept ? beat_batch : s1_batch_q;
    s1_sad_d   = s1_sad_q;
    if (accept) begin
      for (int unsigned p = 0; p < PIXELS_IN_BATCH; p++) begin
        s1_sad_d[p] = '0;
        for (int unsigned r = 0; r < EDGE_LEN; r++) begin
          s1_sad_d[p] = s1_sad_d[p] + SAD_BIT_WIDTH'(
            psad_addend_batch[(p*EDGE_LEN + r)*PSAD_BIT_WIDTH +: PSAD_BIT_WIDTH]);
        end
      end
    end
  end

  always_comb begin
    s2_vld_d   = s1_vld_q && !start_i;
    s2_batch_d = s1_batch_q;
    s2_sad_d   = s1_sad_q[0];
    s2_lidx_d  = '0;
    // strict compare in ascending order keeps the lowest index on ties
    for (int unsigned p = 1; p < PIXELS_IN_BATCH; p++) begin
      if (s1_sad_q[p] < s2_sad_d) begin
        s2_sad_d  = s1_sad_q[p];
        s2_lidx_d = LIDX_W'(p);
      end
    end
  end

  always_comb begin
    s2_gidx   = IDX_WIDTH'(s2_batch_q) * IDX_WIDTH'(PIXELS_IN_BATCH) + IDX_WIDTH'(s2_lidx_q);
    run_sad_d = run_sad_q;
    run_idx_d = run_idx_q;
    if (s2_vld_q && !start_i && (s2_batch_q == '0 || s2_sad_q < run_sad_q)) begin
      run_sad_d = s2_sad_q;
      run_idx_d = s2_gidx;
    end
    best_sad_d = load_best ? run_sad_d : best_sad_q;
    best_idx_d = load_best ? run_idx_d : best_idx_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      batch_q    <= '0;
      drain_q    <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_batch_q <= '0;
      s1_sad_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_batch_q <= '0;
      s2_sad_q   <= '0;
      s2_lidx_q  <= '0;
      run_sad_q  <= '0;
      run_idx_q  <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      batch_q    <= batch_d;
      drain_q    <= drain_d;
      s1_vld_q   <= s1_vld_d;
      s1_batch_q <= s1_batch_d;
      s1_sad_q   <= s1_sad_d;
      s2_vld_q   <= s2_vld_d;
      s2_batch_q <= s2_batch_d;
      s2_sad_q   <= s2_sad_d;
      s2_lidx_q  <= s2_lidx_d;
      run_sad_q  <= run_sad_d;
      run_idx_q  <= run_idx_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign best_sad_o = best_sad_q;
  assign best_idx_o = best_idx_q;

endmodule

// File: tb/tb_sad_min_search.sv
// Directed bench for sad_min_search with a reference model feeding a result
// scoreboard that is drained on every done_o pulse.
module tb_sad_min_search;
  localparam int PIB = 16;
  localparam int EL  = 8;
  localparam int PW  = 11;
  localparam int SW  = 14;
  localparam int NB  = 4;
  localparam int IW  = $clog2(NB * PIB);
  localparam int TOT = PW * EL * PIB;

  logic           clk_i   = 1'b0;
  logic           rst_n_i = 1'b1;
  logic           start_i = 1'b0;
  logic           valid_i = 1'b0;
  logic [TOT-1:0] psad    = '0;
  logic           busy_o, done_o;
  logic [SW-1:0]  best_sad_o;
  logic [IW-1:0]  best_idx_o;

  int checks   = 0;
  int passed   = 0;
  int done_cnt = 0;
  int exp_sad_q[$];
  int exp_idx_q[$];
  bit m_active = 1'b0;
  int m_batch  = 0;
  int m_best   = 0;
  int m_idx    = 0;

  sad_min_search #(
    .PIXELS_IN_BATCH(PIB),
    .EDGE_LEN       (EL),
    .PSAD_BIT_WIDTH (PW),
    .SAD_BIT_WIDTH  (SW),
    .NUM_BATCHES    (NB)
  ) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .start_i          (start_i),
    .valid_i          (valid_i),
    .psad_addend_batch(psad),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .best_sad_o       (best_sad_o),
    .best_idx_o       (best_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic fill_all(input int v);
    for (int p = 0; p < PIB; p++)
      for (int r = 0; r < EL; r++)
        psad[(p*EL + r)*PW +: PW] = PW'(v);
  endtask

  task automatic set_cand(input int p, input int v);
    for (int r = 0; r < EL; r++) psad[(p*EL + r)*PW +: PW] = PW'(v);
  endtask

  // candidate SAD of exactly 100 from uneven rows: 7*12 + 16
  task automatic set_cand100(input int p);
    set_cand(p, 12);
    psad[(p*EL + EL - 1)*PW +: PW] = PW'(16);
  endtask

  task automatic step(input bit st, input bit vl);
    int s;
    @(negedge clk_i);
    start_i = st;
    valid_i = vl;
    if (st) begin
      m_active = 1'b1;
      m_batch  = 0;
    end
    if (vl && m_active) begin
      for (int p = 0; p < PIB; p++) begin
        s = 0;
        for (int r = 0; r < EL; r++) s += int'(psad[(p*EL + r)*PW +: PW]);
        if ((m_batch == 0 && p == 0) || s < m_best) begin
          m_best = s;
          m_idx  = m_batch * PIB + p;
        end
      end
      m_batch++;
      if (m_batch == NB) begin
        exp_sad_q.push_back(m_best);
        exp_idx_q.push_back(m_idx);
        m_active = 1'b0;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  // called right after the edge that accepted the last beat
  task automatic wait_done(input string tag);
    int lat = 1;
    while (done_o !== 1'b1 && lat < 12) begin
      chk({tag, "_busy_drain"}, busy_o, 1);
      step(1'b0, 1'b0);
      lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_busy_done"}, busy_o, 1);
    step(1'b0, 1'b0);
    chk({tag, "_done_width"}, done_o, 0);
    chk({tag, "_busy_after"}, busy_o, 0);
  endtask

  always @(negedge clk_i) begin
    if (done_o === 1'b1) begin
      done_cnt++;
      chk("sb_pending", exp_sad_q.size() != 0, 1);
      if (exp_sad_q.size() != 0) begin
        chk("sb_sad", best_sad_o, exp_sad_q.pop_front());
        chk("sb_idx", best_idx_o, exp_idx_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int acc;

    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_sad", best_sad_o, 0);
    chk("rst_idx", best_idx_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // minimum detection
    fill_all(2040);
    step(1'b1, 1'b0);
    chk("min_busy_start", busy_o, 1);
    for (int b = 0; b < NB; b++) begin
      fill_all(2040);
      if (b == 2) set_cand(5, 1);
      step(1'b0, 1'b1);
    end
    wait_done("min");
    chk("min_sad", best_sad_o, 8);
    chk("min_idx", best_idx_o, 37);

    // ties: earliest global index wins
    fill_all(2040);
    set_cand100(3);
    step(1'b1, 1'b1);
    fill_all(2040);
    set_cand100(3);
    set_cand100(7);
    set_cand100(9);
    step(1'b0, 1'b1);
    for (int b = 2; b < NB; b++) begin
      fill_all(2040);
      step(1'b0, 1'b1);
    end
    wait_done("tie");
    chk("tie_sad", best_sad_o, 100);
    chk("tie_idx", best_idx_o, 3);

    // full-scale SADs
    fill_all(2040);
    step(1'b1, 1'b0);
    for (int b = 0; b < NB; b++) step(1'b0, 1'b1);
    wait_done("wide");
    chk("wide_sad", best_sad_o, 16320);
    chk("wide_idx", best_idx_o, 0);

    // bubbles, with zero-SAD beats offered while idle
    fill_all(0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_o, 0);
    fill_all(2040);
    step(1'b1, 1'b0);
    chk("bub_busy_start", busy_o, 1);
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      fill_all(2040);
      if (pat[i] && acc == NB - 1) set_cand(15, 0);
      step(1'b0, pat[i]);
      if (pat[i]) acc++;
      if (i < 6) chk("bub_busy", busy_o, 1);
    end
    wait_done("bub");
    chk("bub_sad", best_sad_o, 0);
    chk("bub_idx", best_idx_o, 63);

    // abort after two beats; restart beat is batch 0
    fill_all(2040);
    set_cand(0, 0);
    step(1'b1, 1'b1);
    fill_all(2040);
    step(1'b0, 1'b1);
    fill_all(2040);
    set_cand(4, 10);
    step(1'b1, 1'b1);
    for (int b = 1; b < NB; b++) begin
      fill_all(2040);
      step(1'b0, 1'b1);
    end
    wait_done("abort");
    chk("abort_sad", best_sad_o, 80);
    chk("abort_idx", best_idx_o, 4);

    // asynchronous reset in the middle of a window
    fill_all(2040);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    #2 rst_n_i = 1'b0;
    m_active = 1'b0;
    #1;
    chk("mrst_busy", busy_o, 0);
    chk("mrst_done", done_o, 0);
    chk("mrst_sad", best_sad_o, 0);
    chk("mrst_idx", best_idx_o, 0);
    #2 rst_n_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      chk("mrst_no_done", done_o, 0);
    end
    fill_all(2040);
    step(1'b1, 1'b0);
    for (int b = 0; b < NB; b++) begin
      fill_all(2040);
      if (b == 1) set_cand(1, 3);
      step(1'b0, 1'b1);
    end
    wait_done("fresh");
    chk("fresh_sad", best_sad_o, 24);
    chk("fresh_idx", best_idx_o, 17);

    step(1'b0, 1'b0);
    chk("sb_empty", exp_sad_q.size(), 0);
    chk("done_count", done_cnt, 6);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sad_min_search.md
Name: sad_min_search

Overview:
- Sits directly downstream of the absolute-difference array and consumes its per-row partial SADs (psad_addend_batch).
- Each cycle it reduces EDGE_LEN partial SADs per candidate into a full block SAD, then finds the best candidate in the batch.
- It tracks the running minimum over a search window of NUM_BATCHES accepted beats.
- It reports the best SAD and its global candidate index to the motion-vector stage.

Parameters:
- PIXELS_IN_BATCH, 16, candidates per beat.
- EDGE_LEN, 8, partial SADs (rows) per candidate.
- PSAD_BIT_WIDTH, 11, width of each partial SAD; maximum value 2040.
- SAD_BIT_WIDTH, 14, full SAD width; maximum value 16320, so no saturation is needed.
- NUM_BATCHES, 64, beats per search window.
- IDX_WIDTH (localparam), $clog2(NUM_BATCHES*PIXELS_IN_BATCH) = 10, global candidate index width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle pulse that begins a new search window.
- valid_i  input  1  psad_addend_batch holds a valid beat this cycle.
- psad_addend_batch  input  PSAD_BIT_WIDTH*EDGE_LEN*PIXELS_IN_BATCH  partial SADs; candidate p, row r at [(p*EDGE_LEN+r)*PSAD_BIT_WIDTH +: PSAD_BIT_WIDTH].
- busy_o  output  1  a search is in progress.
- done_o  output  1  one-cycle pulse; results are valid.
- best_sad_o  output  SAD_BIT_WIDTH  minimum SAD of the last completed search.
- best_idx_o  output  IDX_WIDTH  batch*PIXELS_IN_BATCH + candidate of that minimum.

Behaviour:
- Reset (rst_n_i low, asynchronous): FSM goes to IDLE; all pipeline valid bits clear; batch counter = 0; busy_o=0, done_o=0, best_sad_o=0, best_idx_o=0.
- Reset asserted mid-search discards the search; no done_o is issued.
- FSM states:
  - IDLE: start_i -> ACCUM. valid_i without start_i is ignored.
  - ACCUM: each cycle with valid_i high is accepted and the batch counter increments. When beat NUM_BATCHES-1 is accepted -> DRAIN. Further valid_i in DRAIN is ignored.
  - DRAIN: 2 cycles while the pipeline empties -> DONE.
  - DONE: done_o=1 for exactly one cycle -> IDLE.
- busy_o = 1 in ACCUM, DRAIN and DONE.
- start_i while busy: abort the current search, clear pipeline valid bits and counter, enter ACCUM. done_o does not fire for the aborted search.
- start_i and valid_i in the same cycle: that beat is accepted as batch 0 of the new search.
- Pipeline (beat accepted at edge t):
  - S1 (registered at t): per-candidate full SAD = unsigned sum of EDGE_LEN partial SADs, SAD_BIT_WIDTH wide, with its batch number.
  - S2 (t+1): batch minimum plus local candidate index. Ties resolve to the lowest candidate index.
  - S3 (t+2): running best update.
    - Batch 0 loads unconditionally.
    - Later batches replace the running best only if strictly less, so ties keep the earlier (lower) global index.
- done_o rises in the cycle following the S3 update of the last beat, i.e. 3 clock cycles after the last beat is accepted.
- best_sad_o and best_idx_o update together with done_o and hold until the next completed search.
- Intermediate running values are not visible on the outputs.
- Gaps in valid_i are allowed at any point; only accepted beats count.

Test Plan:
- Minimum detection, NUM_BATCHES=4:
  - Stimulus: all partial SADs 2040; batch 2, candidate 5 has all rows = 1.
  - Required: done_o pulses exactly 3 cycles after the 4th beat; best_sad_o=8; best_idx_o=37.
- Tie handling:
  - Stimulus: batch 0 candidate 3 and batch 1 candidate 3 both SAD 100; also batch 1 candidates 7 and 9 at SAD 100; all others higher.
  - Required: best_idx_o=3, best_sad_o=100.
- Width boundary:
  - Stimulus: every partial SAD = 2040.
  - Required: best_sad_o=16320, best_idx_o=0, no wrap.
- Bubbles:
  - Stimulus: NUM_BATCHES=4; valid_i pattern 1,0,0,1,1,0,1; valid_i pulses in IDLE before start_i.
  - Required: IDLE pulses ignored; done_o 3 cycles after the 4th accepted beat; busy_o high from the cycle after start_i through the done_o cycle.
- Abort:
  - Stimulus: start_i re-issued after 2 beats, together with valid_i.
  - Required: no done_o for the first search; the beat sent with start_i counts as batch 0; indices are from the new search only.
- Reset mid-search:
  - Stimulus: rst_n_i low for 3 ns, between clock edges, in ACCUM.
  - Required: all outputs 0 immediately; no done_o; a fresh start_i then completes normally.
